// File: rtl/wb_master_pkg.sv
// ============================================================================
//  Module      : wb_master_pkg
//  Description : Shared types and constants for the Wishbone command master:
//                FSM state encoding, bus widths and harness register map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_master_pkg;

  // Wishbone bus widths
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Harness register map, shared by benches and on-chip controllers
  localparam logic [WB_ADR_W-1:0] ADDR_ACTIVE = 32'h3000_0000;
  localparam logic [WB_ADR_W-1:0] ADDR_OEB0   = 32'h3000_0004;
  localparam logic [WB_ADR_W-1:0] ADDR_OEB1   = 32'h3000_0008;
  localparam logic [WB_ADR_W-1:0] ADDR_WS2812 = 32'h3000_0100;
  localparam logic [WB_ADR_W-1:0] ADDR_7SEG   = 32'h3000_0200;
  localparam logic [WB_ADR_W-1:0] ADDR_FREQ   = 32'h3000_0400;

  // Master FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_cmd_master.sv
// ============================================================================
//  Module      : wb_cmd_master
//  Description : Wishbone classic single-cycle initiator. Takes one command on
//                a valid/ready port, runs one read or write with an ack
//                timeout, and returns data/status on a valid/ready response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TCNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_timeout,
  // Wishbone initiator
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,
  // status
  output logic                busy,
  output logic [TCNT_W-1:0]   timeout_count
);

  // Wide enough to hold TIMEOUT_CYCLES, so the wait counter never wraps
  localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [WCNT_W-1:0] wait_cnt;

  logic accept;
  logic bus_ack;
  logic bus_expire;
  logic rsp_fire;

  // Ack is only meaningful in BUS; it wins over an expiring wait counter
  assign accept     = (state == S_IDLE) && cmd_valid;
  assign bus_ack    = (state == S_BUS) && wbm_ack_i;
  assign bus_expire = (state == S_BUS) && !wbm_ack_i && (wait_cnt == WAIT_LAST);
  assign rsp_fire   = (state == S_RESP) && rsp_valid && rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; GAP is a fixed one-cycle hold-off against stale acks
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)                  state_next = S_BUS;
      S_BUS:   if (bus_ack || bus_expire)   state_next = S_RESP;
      S_RESP:  if (rsp_fire)                state_next = S_GAP;
      S_GAP:                                state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
  end

  // Decoded (unregistered) outputs
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
  end

  // Registered bus, response and counter datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      wbm_cyc_o     <= 1'b0;
      wbm_stb_o     <= 1'b0;
      wbm_we_o      <= 1'b0;
      wbm_sel_o     <= '0;
      wbm_adr_o     <= '0;
      wbm_dat_o     <= '0;
      rsp_valid     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_dat       <= '0;
      timeout_count <= '0;
      wait_cnt      <= '0;
    end else begin
      if (accept) begin
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wait_cnt  <= '0;
      end

      if (bus_ack) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_dat     <= wbm_we_o ? '0 : wbm_dat_i;
        rsp_timeout <= 1'b0;
        rsp_valid   <= 1'b1;
      end else if (bus_expire) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_dat     <= '0;
        rsp_timeout <= 1'b1;
        rsp_valid   <= 1'b1;
        if (timeout_count != '1) begin
          timeout_count <= timeout_count + TCNT_W'(1);
        end
      end else if (state == S_BUS) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end

      if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
//  Module      : tb_wb_cmd_master
//  Description : Self-checking bench for wb_cmd_master with a harness-like
//                Wishbone slave (programmable ack delay, optional stale ack,
//                idle-time ack noise) and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;
  import wb_master_pkg::*;

  localparam int TO     = 255;
  localparam int TW     = 2;
  localparam int TC_MAX = (1 << TW) - 1;

  localparam logic [31:0] MAP [6] = '{ADDR_ACTIVE, ADDR_OEB0, ADDR_OEB1,
                                      ADDR_WS2812, ADDR_7SEG, ADDR_FREQ};

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [3:0]    cmd_sel;
  logic [31:0]   cmd_adr, cmd_dat;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0]   rsp_dat;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic          busy;
  logic [TW-1:0] timeout_count;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO), .TCNT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // ---------------- harness-like slave ----------------
  function automatic int slot(input logic [31:0] a);
    for (int i = 0; i < 6; i++) if (MAP[i] == a) return i;
    return -1;
  endfunction

  logic [31:0] sregs [6];
  int          ack_delay = 0;
  int          stb_cnt   = 0;
  int          s_slot;
  logic        ack_comb;
  logic        ack_prev  = 1'b0;
  logic        stale_en  = 1'b0;
  logic        noise_en  = 1'b0;
  logic        noise     = 1'b0;
  logic [31:0] junk      = 32'h0;

  always_comb s_slot = slot(wbm_adr_o);

  always_comb begin
    ack_comb = wbm_cyc_o && wbm_stb_o && (s_slot >= 0) && (stb_cnt == ack_delay);
  end

  always_comb begin
    wbm_dat_i = junk;
    if (s_slot >= 0) wbm_dat_i = sregs[s_slot];
  end

  // Stale ack models a registered slave ack lingering one cycle after stb drops
  assign wbm_ack_i = ack_comb | (stale_en & ack_prev) | (noise & ~wbm_cyc_o);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) sregs[i] <= 32'h0;
      stb_cnt  <= 0;
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= ack_comb;
      if (wbm_cyc_o && wbm_stb_o && !ack_comb) stb_cnt <= stb_cnt + 1;
      else                                     stb_cnt <= 0;
      if (ack_comb && wbm_we_o) begin
        for (int b = 0; b < 4; b++)
          if (wbm_sel_o[b]) sregs[s_slot][b*8 +: 8] <= wbm_dat_o[b*8 +: 8];
      end
    end
  end

  always @(negedge clk) begin
    noise <= noise_en && ($urandom % 4 == 0);
    junk  <= $urandom;
  end

  // ---------------- reference model and checking ----------------
  logic [31:0] mregs [6];
  int          tc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mregs[i] = 32'h0;
    tc = 0;
  endtask

  // One complete command: issue, watch the bus, check response, release it
  task automatic do_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input int delay, input int hold);
    int          s, n, w, exp_n;
    logic        exp_to, ok_bus, ok_hold;
    logic [31:0] exp_dat;
    s       = slot(adr);
    exp_to  = (s < 0) || (delay >= TO);
    exp_n   = exp_to ? TO : delay + 1;
    exp_dat = 32'h0;
    if (!exp_to && !we) exp_dat = mregs[s];
    if (!exp_to && we)
      for (int b = 0; b < 4; b++) if (sel[b]) mregs[s][b*8 +: 8] = dat[b*8 +: 8];
    if (exp_to) tc = (tc == TC_MAX) ? TC_MAX : tc + 1;
    ack_delay = delay;

    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    @(posedge clk);
    @(negedge clk);
    n = 0; ok_bus = 1'b1;
    while (wbm_stb_o && n < TO + 10) begin
      ok_bus &= wbm_cyc_o && (wbm_we_o == we) && (wbm_sel_o == sel) &&
                (wbm_adr_o == adr) && (wbm_dat_o == dat) && !cmd_ready && busy && !rsp_valid;
      // garbage on the command port while busy must be ignored
      cmd_valid = 1'($urandom); cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("stb_cycles", n, exp_n);
    chk("bus_stable", ok_bus, 1);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("timeout_count", timeout_count, tc);

    ok_hold = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ok_hold &= rsp_valid && (rsp_dat == exp_dat) && (rsp_timeout == exp_to) &&
                 !cmd_ready && !wbm_cyc_o && !wbm_stb_o;
    end
    if (hold > 0) chk("rsp_hold", ok_hold, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("gap_state", {rsp_valid, busy, cmd_ready}, 3'b010);
    @(negedge clk);
    chk("idle_state", {busy, cmd_ready, wbm_stb_o}, 3'b010);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses, rsps, low_run, gap, sidx, nrsp;
    logic prev_stb;
    logic [31:0] radr;

    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0;
    cmd_adr = 32'h0; cmd_dat = 32'h0; rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 7'h0);
    chk("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_dat}, 34'h0);
    chk("rst_status", {timeout_count, busy, cmd_ready}, {{TW{1'b0}}, 2'b01});
    reset = 1'b0;
    noise_en = 1'b1;
    @(negedge clk);

    // write active project, read it back
    do_cmd(1'b1, 4'hF, ADDR_ACTIVE, 32'h0000_0003, 0, 0);
    chk("harness_active", sregs[0], 32'h3);
    do_cmd(1'b0, 4'hF, ADDR_ACTIVE, 32'h0, 0, 0);
    // unmapped read times out after exactly TO strobe cycles
    do_cmd(1'b0, 4'hF, 32'h3000_0F00, 32'h0, 0, 0);
    // response backpressure with a stale ack behind it
    stale_en = 1'b1;
    do_cmd(1'b1, 4'h5, ADDR_OEB1, 32'hA5C3_7E19, 2, 10);
    do_cmd(1'b0, 4'hF, ADDR_OEB1, 32'h0, 1, 10);
    // ack on the last allowed cycle wins; one later is a timeout
    do_cmd(1'b0, 4'hF, ADDR_OEB1, 32'h0, TO - 1, 0);
    do_cmd(1'b0, 4'hF, ADDR_OEB1, 32'h0, TO, 0);
    // drive timeout_count into saturation
    do_cmd(1'b0, 4'hF, 32'h3000_0F04, 32'h0, 0, 0);
    do_cmd(1'b1, 4'hF, 32'h3000_0F08, 32'h1234_5678, 0, 1);

    // back-to-back with cmd_valid and rsp_ready held high
    ack_delay = 0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = ADDR_OEB0; cmd_dat = 32'hFFFF_FFFF;
    mregs[1] = 32'h0;
    pulses = 0; rsps = 0; low_run = 0; gap = 0; prev_stb = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wbm_stb_o && !prev_stb) begin
        pulses++;
        if (pulses == 1) cmd_dat = 32'h0;
        else begin cmd_valid = 1'b0; gap = low_run; end
      end
      low_run  = wbm_stb_o ? 0 : low_run + 1;
      if (rsp_valid) rsps++;
      prev_stb = wbm_stb_o;
    end
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_responses", rsps, 2);
    chk("b2b_gap_ge3", gap >= 3, 1);
    chk("b2b_oeb0", sregs[1], 32'h0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      sidx = $urandom % 7;
      if (sidx < 6) radr = MAP[sidx];
      else          radr = 32'h3000_0F00 + 32'(($urandom % 8) * 4);
      stale_en = 1'($urandom);
      do_cmd(1'($urandom), 4'($urandom), radr, $urandom, $urandom % 5, $urandom % 4);
    end
    for (int i = 0; i < 6; i++) chk("final_reg", sregs[i], mregs[i]);

    // reset in the 5th cycle of a timing-out transaction
    chk("tc_before_reset", timeout_count, tc);
    ack_delay = 1000;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = ADDR_FREQ;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, rsp_valid}, 3'b000);
    chk("rst_mid_state", {busy, cmd_ready}, 2'b01);
    chk("rst_mid_tcount", timeout_count, 0);
    reset = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || wbm_stb_o) nrsp++;
    end
    rsp_ready = 1'b0;
    chk("no_rsp_after_reset", nrsp, 0);
    do_cmd(1'b0, 4'hF, ADDR_ACTIVE, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
